// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data_memory port between two requesters, one
// transaction at a time, with registered outputs and a read watchdog.
module dmem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int TIMEOUT    = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_r0_req,
    input  logic              i_r0_we,
    input  logic [ADDR_W-1:0] i_r0_addr,
    input  logic [DATA_W-1:0] i_r0_wdata,
    input  logic              i_r1_req,
    input  logic              i_r1_we,
    input  logic [ADDR_W-1:0] i_r1_addr,
    input  logic [DATA_W-1:0] i_r1_wdata,
    output logic              o_r0_gnt,
    output logic              o_r0_valid,
    output logic [DATA_W-1:0] o_r0_rdata,
    output logic              o_r0_err,
    output logic              o_r1_gnt,
    output logic              o_r1_valid,
    output logic [DATA_W-1:0] o_r1_rdata,
    output logic              o_r1_err,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic [DATA_W-1:0] o_m_data,
    output logic              o_m_MemRead,
    output logic              o_m_MemWrite,
    input  logic              i_m_valid,
    input  logic [DATA_W-1:0] i_m_data
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              valid0_q, valid0_d, valid1_q, valid1_d;
    logic              err0_q, err0_d, err1_q, err1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              mread_q, mread_d, mwrite_q, mwrite_d;

    logic              win_s, pick1_s, sel_we_s, timeout_s, resp_err_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s, resp_data_s;
    logic [CNT_W-1:0]  cnt_inc_s;

    // Arbitration: last_q holds the id granted most recently
    always_comb begin
        win_s = i_r0_req | i_r1_req;
        if (FIXED_PRIO != 0) begin
            pick1_s = i_r1_req & ~i_r0_req;
        end else begin
            pick1_s = i_r1_req & (~i_r0_req | ~last_q);
        end
        sel_we_s    = pick1_s ? i_r1_we    : i_r0_we;
        sel_addr_s  = pick1_s ? i_r1_addr  : i_r0_addr;
        sel_wdata_s = pick1_s ? i_r1_wdata : i_r0_wdata;
        cnt_inc_s   = cnt_q + CNT_W'(1);
        timeout_s   = (cnt_inc_s == CNT_W'(TIMEOUT));
    end

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= {CNT_W{1'b0}};
            addr_q   <= {ADDR_W{1'b0}};
            wdata_q  <= {DATA_W{1'b0}};
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= {DATA_W{1'b0}};
            rdata1_q <= {DATA_W{1'b0}};
            mread_q  <= 1'b0;
            mwrite_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            mread_q  <= mread_d;
            mwrite_q <= mwrite_d;
        end
    end

    // Next-state logic; a response arriving in READ skips WAIT
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (win_s) begin
                    state_d = sel_we_s ? S_WRITE : S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: state_d = S_RESP;
            S_READ: begin
                if (i_m_valid) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_m_valid || timeout_s) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; memory valid beats the watchdog
    always_comb begin
        owner_d     = owner_q;
        last_d      = last_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        mread_d     = 1'b0;
        mwrite_d    = 1'b0;
        resp_data_s = {DATA_W{1'b0}};
        resp_err_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_s) begin
                    owner_d  = pick1_s;
                    last_d   = pick1_s;
                    addr_d   = sel_addr_s;
                    wdata_d  = sel_wdata_s;
                    cnt_d    = {CNT_W{1'b0}};
                    gnt0_d   = ~pick1_s;
                    gnt1_d   = pick1_s;
                    mwrite_d = sel_we_s;
                    mread_d  = ~sel_we_s;
                end else begin
                    owner_d = owner_q;
                end
            end
            S_READ: begin
                if (i_m_valid) begin
                    resp_data_s = i_m_data;
                end else begin
                    resp_data_s = {DATA_W{1'b0}};
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc_s;
                if (i_m_valid) begin
                    resp_data_s = i_m_data;
                end else if (timeout_s) begin
                    resp_err_s = 1'b1;
                end else begin
                    resp_err_s = 1'b0;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
        valid0_d = (state_d == S_RESP) & ~owner_q;
        valid1_d = (state_d == S_RESP) & owner_q;
        err0_d   = valid0_d & resp_err_s;
        err1_d   = valid1_d & resp_err_s;
        rdata0_d = valid0_d ? resp_data_s : {DATA_W{1'b0}};
        rdata1_d = valid1_d ? resp_data_s : {DATA_W{1'b0}};
    end

    assign o_r0_gnt     = gnt0_q;
    assign o_r1_gnt     = gnt1_q;
    assign o_r0_valid   = valid0_q;
    assign o_r1_valid   = valid1_q;
    assign o_r0_err     = err0_q;
    assign o_r1_err     = err1_q;
    assign o_r0_rdata   = rdata0_q;
    assign o_r1_rdata   = rdata1_q;
    assign o_m_addr     = addr_q;
    assign o_m_data     = wdata_q;
    assign o_m_MemRead  = mread_q;
    assign o_m_MemWrite = mwrite_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-timeline reference model checked every
// cycle, a directed vector table, and randomized traffic with a latency memory.
module tb_dmem_arbiter;
    localparam int TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [63:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic        m_valid;
    logic [63:0] m_data;
    wire         o_r0_gnt, o_r0_valid, o_r0_err, o_r1_gnt, o_r1_valid, o_r1_err;
    wire  [63:0] o_r0_rdata, o_r1_rdata, o_m_addr, o_m_data;
    wire         o_m_MemRead, o_m_MemWrite;

    logic        f_r0_req, f_r1_req;
    wire         f_r0_gnt, f_r0_valid, f_r0_err, f_r1_gnt, f_r1_valid, f_r1_err;
    wire  [63:0] f_r0_rdata, f_r1_rdata, f_m_addr, f_m_data;
    wire         f_MemRead, f_MemWrite;

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TO), .FIXED_PRIO(0)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_r0_req(r0_req), .i_r0_we(r0_we), .i_r0_addr(r0_addr), .i_r0_wdata(r0_wdata),
        .i_r1_req(r1_req), .i_r1_we(r1_we), .i_r1_addr(r1_addr), .i_r1_wdata(r1_wdata),
        .o_r0_gnt(o_r0_gnt), .o_r0_valid(o_r0_valid), .o_r0_rdata(o_r0_rdata), .o_r0_err(o_r0_err),
        .o_r1_gnt(o_r1_gnt), .o_r1_valid(o_r1_valid), .o_r1_rdata(o_r1_rdata), .o_r1_err(o_r1_err),
        .o_m_addr(o_m_addr), .o_m_data(o_m_data), .o_m_MemRead(o_m_MemRead),
        .o_m_MemWrite(o_m_MemWrite), .i_m_valid(m_valid), .i_m_data(m_data));

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TO), .FIXED_PRIO(1)) dutf (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_r0_req(f_r0_req), .i_r0_we(1'b1), .i_r0_addr(64'h100), .i_r0_wdata(64'hAAAA),
        .i_r1_req(f_r1_req), .i_r1_we(1'b1), .i_r1_addr(64'h200), .i_r1_wdata(64'hBBBB),
        .o_r0_gnt(f_r0_gnt), .o_r0_valid(f_r0_valid), .o_r0_rdata(f_r0_rdata), .o_r0_err(f_r0_err),
        .o_r1_gnt(f_r1_gnt), .o_r1_valid(f_r1_valid), .o_r1_rdata(f_r1_rdata), .o_r1_err(f_r1_err),
        .o_m_addr(f_m_addr), .o_m_data(f_m_data), .o_m_MemRead(f_MemRead),
        .o_m_MemWrite(f_MemWrite), .i_m_valid(1'b0), .i_m_data(64'h0));

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endfunction

    // Reference model: one transaction on a timeline of cycle numbers
    typedef struct packed {
        logic        gnt0, gnt1, valid0, valid1, err0, err1;
        logic [63:0] rdata0, rdata1, m_addr, m_data;
        logic        mread, mwrite;
    } exp_t;

    exp_t        expc = '0;
    int          cyc = 0, start_c = 0, resp_c = -1;
    bit          idle_m = 1'b1, own = 1'b0, wr = 1'b0, last_id = 1'b1, res_err = 1'b0;
    logic [63:0] res_data = 64'h0;

    function automatic void model_edge();
        exp_t n;
        n = '0;
        n.m_addr = expc.m_addr;
        n.m_data = expc.m_data;
        if (!rst_n) begin
            n.m_addr = 64'h0;
            n.m_data = 64'h0;
            idle_m   = 1'b1;
            last_id  = 1'b1;
        end else if (idle_m) begin
            if (r0_req || r1_req) begin
                own      = r1_req && (!r0_req || last_id == 1'b0);
                last_id  = own;
                wr       = own ? r1_we : r0_we;
                n.gnt0   = !own;
                n.gnt1   = own;
                n.m_addr = own ? r1_addr : r0_addr;
                n.m_data = own ? r1_wdata : r0_wdata;
                n.mwrite = wr;
                n.mread  = !wr;
                idle_m   = 1'b0;
                start_c  = cyc + 1;
                resp_c   = wr ? cyc + 2 : -1;
                res_data = 64'h0;
                res_err  = 1'b0;
            end
        end else begin
            if (resp_c < 0) begin
                if (m_valid) begin
                    resp_c = cyc + 1; res_data = m_data; res_err = 1'b0;
                end else if (cyc == start_c + TO) begin
                    resp_c = cyc + 1; res_data = 64'h0; res_err = 1'b1;
                end
            end
            if (resp_c == cyc + 1) begin
                n.valid0 = !own; n.valid1 = own;
                n.err0 = !own && res_err; n.err1 = own && res_err;
                n.rdata0 = own ? 64'h0 : res_data;
                n.rdata1 = own ? res_data : 64'h0;
            end else if (resp_c == cyc) begin
                idle_m = 1'b1;
            end
        end
        cyc++;
        expc = n;
    endfunction

    function automatic void check_cycle();
        chk("r0_gnt", 64'(o_r0_gnt), 64'(expc.gnt0));
        chk("r1_gnt", 64'(o_r1_gnt), 64'(expc.gnt1));
        chk("r0_valid", 64'(o_r0_valid), 64'(expc.valid0));
        chk("r1_valid", 64'(o_r1_valid), 64'(expc.valid1));
        chk("r0_err", 64'(o_r0_err), 64'(expc.err0));
        chk("r1_err", 64'(o_r1_err), 64'(expc.err1));
        if (expc.valid0) chk("r0_rdata", o_r0_rdata, expc.rdata0);
        if (expc.valid1) chk("r1_rdata", o_r1_rdata, expc.rdata1);
        chk("m_addr", o_m_addr, expc.m_addr);
        chk("m_data", o_m_data, expc.m_data);
        chk("MemRead", 64'(o_m_MemRead), 64'(expc.mread));
        chk("MemWrite", 64'(o_m_MemWrite), 64'(expc.mwrite));
    endfunction

    // Memory: valid comes mem_lat+1 cycles after the MemRead cycle (-1 = same cycle, >=50 = never)
    logic [63:0] mem [logic [63:0]];
    int          mem_lat = 0, rd_cd = 0;
    bit          rand_mode = 1'b0;
    logic [63:0] rd_val = 64'h0;

    task automatic mem_respond();
        int l;
        m_valid = 1'b0;
        m_data  = 64'h0;
        if (!rst_n) rd_cd = 0;
        if (rd_cd > 0) begin
            rd_cd--;
            if (rd_cd == 0) begin m_valid = 1'b1; m_data = rd_val; end
        end
        if (o_m_MemWrite) mem[o_m_addr] = o_m_data;
        if (o_m_MemRead) begin
            l = rand_mode ? int'($urandom_range(0, 6)) - 1 : mem_lat;
            rd_val = mem.exists(o_m_addr) ? mem[o_m_addr] : 64'h0;
            if (l < 0) begin m_valid = 1'b1; m_data = rd_val; end
            else if (l < 50) rd_cd = l + 1;
        end
        if (rand_mode && !m_valid && $urandom_range(0, 7) == 0) begin
            m_valid = 1'b1;
            m_data  = {$urandom, $urandom};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_cycle();
        mem_respond();
    endtask

    task automatic set_req(input bit id, input bit rq, input bit we, input logic [63:0] a, input logic [63:0] d);
        if (id) begin r1_req = rq; r1_we = we; r1_addr = a; r1_wdata = d; end
        else begin r0_req = rq; r0_we = we; r0_addr = a; r0_wdata = d; end
    endtask

    typedef struct {
        bit          id;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          lat;
        int          exp_lat;
        bit          exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t tbl [8];
    int   ord [4];

    initial begin
        int k, got, fg0, fg1, fv;
        bit fsaw_rd, fsaw_err, fsaw_g1;

        tbl[0] = '{1'b0, 1'b1, 64'h10, 64'h1122334455667788, 0, 2, 1'b0, 64'h0};
        tbl[1] = '{1'b1, 1'b0, 64'h10, 64'h0, 2, 5, 1'b0, 64'h1122334455667788};
        tbl[2] = '{1'b0, 1'b0, 64'h10, 64'h0, 99, 6, 1'b1, 64'h0};
        tbl[3] = '{1'b1, 1'b1, 64'h18, 64'hDEADBEEFCAFEF00D, 0, 2, 1'b0, 64'h0};
        tbl[4] = '{1'b0, 1'b0, 64'h18, 64'h0, -1, 2, 1'b0, 64'hDEADBEEFCAFEF00D};
        tbl[5] = '{1'b1, 1'b0, 64'h10, 64'h0, 3, 6, 1'b0, 64'h1122334455667788};
        tbl[6] = '{1'b0, 1'b0, 64'h18, 64'h0, 0, 3, 1'b0, 64'hDEADBEEFCAFEF00D};
        tbl[7] = '{1'b1, 1'b1, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFFF, 0, 2, 1'b0, 64'h0};

        rst_n = 1'b0; m_valid = 1'b0; m_data = 64'h0;
        set_req(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        set_req(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
        f_r0_req = 1'b0; f_r1_req = 1'b0;
        tick(); tick();
        chk("reset_outputs", {o_r0_gnt, o_r1_gnt, o_r0_valid, o_r1_valid, o_m_MemRead,
            o_m_MemWrite, o_r0_err, o_r1_err}, 64'h0);
        chk("reset_m_addr", o_m_addr, 64'h0);
        rst_n = 1'b1;
        tick();

        // Contention: both held; round-robin alternates, fixed priority keeps r0
        set_req(1'b0, 1'b1, 1'b1, 64'h20, 64'h2020);
        set_req(1'b1, 1'b1, 1'b1, 64'h28, 64'h2828);
        f_r0_req = 1'b1; f_r1_req = 1'b1;
        for (int i = 0; i < 4; i++) ord[i] = 2;
        got = 0; k = 0; fg0 = 0; fg1 = 0; fv = 0; fsaw_rd = 1'b0; fsaw_err = 1'b0;
        while (got < 4 && k < 30) begin
            tick(); k++;
            if (o_r0_gnt && got < 4) begin ord[got] = 0; got++; end
            if (o_r1_gnt && got < 4) begin ord[got] = 1; got++; end
            fg0 += int'(f_r0_gnt); fg1 += int'(f_r1_gnt);
            fv += int'(f_r0_valid) + int'(f_r1_valid);
            fsaw_rd |= f_MemRead;
            fsaw_err |= f_r0_err | f_r1_err;
        end
        for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), 64'(ord[i]), 64'(i % 2));
        chk("fixed_r1_starved", 64'(fg1), 64'h0);
        chk("fixed_r0_grants", 64'(fg0 >= 3), 64'h1);
        chk("fixed_valids", 64'(fv >= 2), 64'h1);
        set_req(1'b0, 1'b0, 1'b1, 64'h20, 64'h2020);
        set_req(1'b1, 1'b0, 1'b1, 64'h28, 64'h2828);
        f_r0_req = 1'b0;
        fsaw_g1 = 1'b0;
        for (int i = 0; i < 6 && !fsaw_g1; i++) begin
            tick();
            fsaw_g1 = f_r1_gnt;
            fsaw_rd |= f_MemRead;
            fsaw_err |= f_r0_err | f_r1_err;
        end
        f_r1_req = 1'b0;
        chk("fixed_r1_after_drop", 64'(fsaw_g1), 64'h1);
        for (int i = 0; i < 4; i++) tick();
        chk("fixed_no_read", 64'(fsaw_rd), 64'h0);
        chk("fixed_no_err", 64'(fsaw_err), 64'h0);
        chk("fixed_rdata", f_r0_rdata | f_r1_rdata, 64'h0);
        chk("fixed_m_addr", f_m_addr, 64'h200);
        chk("fixed_m_data", f_m_data, 64'hBBBB);

        // Directed vector table
        for (int v = 0; v < 8; v++) begin
            mem_lat = tbl[v].lat;
            set_req(tbl[v].id, 1'b1, tbl[v].we, tbl[v].addr, tbl[v].wdata);
            k = 0; got = 0;
            while (got == 0 && k < 20) begin
                tick(); k++;
                if (k == 1) begin
                    chk($sformatf("tbl%0d_gnt", v), 64'(tbl[v].id ? o_r1_gnt : o_r0_gnt), 64'h1);
                    set_req(tbl[v].id, 1'b0, tbl[v].we, tbl[v].addr, tbl[v].wdata);
                end
                if (tbl[v].id ? o_r1_valid : o_r0_valid) got = 1;
            end
            chk($sformatf("tbl%0d_latency", v), 64'(k), 64'(tbl[v].exp_lat));
            chk($sformatf("tbl%0d_err", v), 64'(tbl[v].id ? o_r1_err : o_r0_err), 64'(tbl[v].exp_err));
            chk($sformatf("tbl%0d_rdata", v), tbl[v].id ? o_r1_rdata : o_r0_rdata, tbl[v].exp_rdata);
            tick();
        end
        chk("mem_0x10", mem.exists(64'h10) ? mem[64'h10] : 64'h0, 64'h1122334455667788);

        // Stray memory valid while idle produces nothing
        m_valid = 1'b1; m_data = 64'hA5A5A5A5A5A5A5A5;
        tick(); tick();
        chk("stray_idle", {o_r0_valid, o_r1_valid, o_r0_gnt, o_r1_gnt, o_r0_err, o_r1_err}, 64'h0);

        // Reset in WAIT drops the read; r0 wins the next contested grant
        mem_lat = 99;
        set_req(1'b1, 1'b1, 1'b0, 64'h30, 64'h0);
        tick();
        set_req(1'b1, 1'b0, 1'b0, 64'h30, 64'h0);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        chk("rst_wait_quiet", {o_r0_valid, o_r1_valid, o_r0_err, o_r1_err, o_m_MemRead, o_m_MemWrite}, 64'h0);
        chk("rst_wait_addr", o_m_addr, 64'h0);
        rst_n = 1'b1;
        set_req(1'b0, 1'b1, 1'b1, 64'h38, 64'h3838);
        set_req(1'b1, 1'b1, 1'b1, 64'h40, 64'h4040);
        tick();
        chk("rst_first_gnt_r0", {o_r1_gnt, o_r0_gnt}, 64'h1);
        set_req(1'b0, 1'b0, 1'b1, 64'h38, 64'h3838);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (o_r1_gnt) set_req(1'b1, 1'b0, 1'b1, 64'h40, 64'h4040);
        end
        set_req(1'b1, 1'b0, 1'b1, 64'h40, 64'h4040);

        // Randomized traffic with random memory latency and stray valids
        rand_mode = 1'b1;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (r0_req && (o_r0_gnt || $urandom_range(0, 19) == 0)) r0_req = 1'b0;
            else if (!r0_req && $urandom_range(0, 2) == 0)
                set_req(1'b0, 1'b1, 1'($urandom), 64'($urandom_range(0, 7)) << 3, {$urandom, $urandom});
            if (r1_req && (o_r1_gnt || $urandom_range(0, 19) == 0)) r1_req = 1'b0;
            else if (!r1_req && $urandom_range(0, 2) == 0)
                set_req(1'b1, 1'b1, 1'($urandom), 64'($urandom_range(0, 7)) << 3, {$urandom, $urandom});
        end
        rand_mode = 1'b0;
        r0_req = 1'b0; r1_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer that shares the single data_memory instance between the cpu data port (requester 0) and an auxiliary master (requester 1, e.g. a DMA or memory-preload engine).
- Accepts one transaction at a time.
- Drives the memory's MemRead/MemWrite strobes.
- Waits for the memory's o_valid.
- Returns read data or a write acknowledge to the owning requester.
- A watchdog flags reads that never return.

Parameters:
ADDR_W, 64, address width on all ports
DATA_W, 64, data width on all ports
TIMEOUT, 16, max cycles spent in WAIT before a read is failed (>=1)
FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 always wins

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst_n  in  1  synchronous active-low reset
i_r0_req / i_r1_req  in  1  level request, held until grant
i_r0_we / i_r1_we  in  1  1 = write, 0 = read; valid with req
i_r0_addr / i_r1_addr  in  ADDR_W  byte address
i_r0_wdata / i_r1_wdata  in  DATA_W  write data
o_r0_gnt / o_r1_gnt  out  1  one-cycle pulse: request accepted
o_r0_valid / o_r1_valid  out  1  one-cycle pulse: transaction complete
o_r0_rdata / o_r1_rdata  out  DATA_W  read data, meaningful when valid and not err
o_r0_err / o_r1_err  out  1  with valid: read timed out
o_m_addr  out  ADDR_W  to data_memory i_addr
o_m_data  out  DATA_W  to data_memory i_data
o_m_MemRead  out  1  to data_memory i_MemRead
o_m_MemWrite  out  1  to data_memory i_MemWrite
i_m_valid  in  1  from data_memory o_valid
i_m_data  in  DATA_W  from data_memory o_data

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst_n is synchronous, active-low.
- Reset (i_rst_n=0 at a rising edge):
  - State goes to IDLE.
  - All outputs go to 0, including the latched address, data and response registers.
  - The round-robin pointer is set so requester 0 wins the first contested arbitration.
- Reset mid-transaction: the transaction is dropped. No valid/err is issued and the strobes deassert the next cycle.
- FSM states: IDLE, WRITE, READ, WAIT, RESP. All outputs are registered.
- IDLE:
  - The winner is chosen from the req lines sampled this cycle.
  - On the edge the arbiter latches the winner id, we, addr and wdata.
  - It moves to WRITE (we=1) or READ (we=0). The winner's o_gnt is high for exactly the first cycle of WRITE/READ.
  - With no req, it stays in IDLE.
- Arbitration:
  - FIXED_PRIO=1: requester 0 wins whenever its req is high.
  - FIXED_PRIO=0: with both reqs high, the requester not granted last wins. With a single req, it wins regardless of the pointer.
  - The pointer updates only on a grant.
- WRITE: o_m_MemWrite=1 for exactly one cycle, with o_m_addr/o_m_data = latched values. Next state is RESP.
- READ: o_m_MemRead=1 for exactly one cycle. Next state is WAIT.
- Early read response: i_m_valid is honoured from the READ cycle onward. If it is high in READ, the arbiter captures data and goes straight to RESP, skipping WAIT.
- WAIT:
  - The counter increments each cycle.
  - On i_m_valid, i_m_data is captured and the state goes to RESP with err=0.
  - If the counter reaches TIMEOUT without valid, the state goes to RESP with err=1 and rdata=0.
  - If valid and timeout coincide, valid wins (err=0).
  - Counter width is clog2(TIMEOUT+1); it clears on entry to READ.
- RESP:
  - Owner's o_valid=1 for one cycle, plus o_rdata and o_err.
  - For writes, rdata=0 and err=0.
  - Next state is IDLE. The non-owner's outputs stay 0.
- Latency from req (seen in IDLE) to valid:
  - Write: 2 cycles.
  - Read: 3 + N cycles, where N = memory latency after the MemRead cycle.
  - The next grant comes no earlier than the IDLE cycle after RESP, so the minimum spacing is 3 cycles per write.
- Memory-side hold: o_m_addr/o_m_data hold their last latched values between transactions. Strobes are 0 outside WRITE/READ.
- Stray i_m_valid: ignored in IDLE, WRITE and RESP.
- Request withdrawal: a req dropped before its grant is simply not served. Requesters must not change addr/we/wdata while req is high and not yet granted.
- Address handling: addresses are forwarded unmodified; alignment is the memory's concern.

Test Plan:
1. Reset then single write: r0 writes addr=0x10, wdata=0x1122334455667788 → o_r0_gnt at cycle+1, MemWrite pulse same cycle with that addr/data, o_r0_valid at cycle+2, mem[0x10..0x17] updated.
2. Read back with memory latency 2: r1 reads 0x10 → MemRead one cycle, o_r1_valid with rdata=0x1122334455667788, err=0; total 5 cycles from req.
3. Contention, FIXED_PRIO=0: both reqs held high for 4 transactions → grants alternate r0,r1,r0,r1. With FIXED_PRIO=1 → r0 always wins while held.
4. Timeout, TIMEOUT=4, memory never asserts valid: r0 read → o_r0_valid with err=1, rdata=0 after 4 WAIT cycles. A following write completes normally.
5. Boundaries:
   - i_m_valid in READ cycle → RESP next cycle.
   - valid on the same cycle as timeout → err=0.
   - stray i_m_valid in IDLE → no output.
6. Reset asserted during WAIT → no valid/err pulse, outputs 0 next cycle, next transaction granted to r0 first.
